cc_line_serializer: RTL and testbench

Parametrised successor to the cache-line read serializer in the cache controller. It pops one line entry from a first-word-fall-through response FIFO, latches it, and emits it as a valid/ready beat stream to the read-data channel. Two burst modes: critical-word-first wrap, or incrementing from the requested offset to the end of the line. Outputs are fully registered, each entry carries a transaction ID, and back-to-back lines stream with no bubble.

---
 rtl/cc_line_serializer.sv | 135 +++++++++++++
 tb/tb_cc_line_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cc_line_serializer.sv
// cc_line_serializer: pops cache-line entries from a FWFT FIFO and streams them
// as valid/ready beats, wrap (critical-word-first) or incrementing to line end.
//
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   fifo_empty_i    FIFO empty flag; fifo_rdata_i valid when low
//   fifo_rdata_i    {id, mode, offset, line}, beat 0 in the line MSBs
//   fifo_rden_o     pop strobe (combinational)
//   rid_o           transaction ID of the line being sent
//   rdata_o         beat data
//   rlast_o         final beat of the burst
//   rvalid_o        beat valid
//   rready_i        downstream accept
//   busy_o          a line is held (equals rvalid_o)
module cc_line_serializer #(
    parameter int DATA_W = 64,
    parameter int BEATS  = 8,
    parameter int ID_W   = 4,
    localparam int OFF_W   = $clog2(BEATS),
    localparam int ENTRY_W = ID_W + 1 + OFF_W + BEATS * DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fifo_empty_i,
    input  logic [ENTRY_W-1:0] fifo_rdata_i,
    output logic               fifo_rden_o,
    output logic [ID_W-1:0]    rid_o,
    output logic [DATA_W-1:0]  rdata_o,
    output logic               rlast_o,
    output logic               rvalid_o,
    input  logic               rready_i,
    output logic               busy_o
);
    localparam int CW = OFF_W + 1;
    localparam int LW = BEATS * DATA_W;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic              en_q;
    logic [ID_W-1:0]   id_q, id_d;
    logic              mode_q, mode_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [LW-1:0]     line_q, line_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rlast_q, rlast_d;

    logic              acc, lacc, pop;
    logic [ID_W-1:0]   in_id;
    logic              in_mode;
    logic [OFF_W-1:0]  in_off;
    logic [LW-1:0]     in_line;
    logic [CW-1:0]     cnt_nx, len_m1;
    logic [OFF_W-1:0]  idx_nx;

    function automatic logic [DATA_W-1:0] beat_of(input logic [LW-1:0] l, input logic [OFF_W-1:0] b);
        return l[(BEATS - 1 - int'(b)) * DATA_W +: DATA_W];
    endfunction

    assign in_id   = fifo_rdata_i[ENTRY_W-1 -: ID_W];
    assign in_mode = fifo_rdata_i[LW + OFF_W];
    assign in_off  = fifo_rdata_i[LW +: OFF_W];
    assign in_line = fifo_rdata_i[LW-1:0];

    assign acc  = (state_q == SEND) & rready_i;
    assign lacc = acc & rlast_q;
    // en_q keeps the combinational pop strobe low while reset is held and
    // on the first cycle after release, without reusing rst_n as data.
    assign pop  = en_q & !fifo_empty_i & ((state_q == IDLE) | lacc);

    // Counter runs one bit wider than the offset; the beat index wraps mod BEATS.
    assign cnt_nx = cnt_q + CW'(1);
    assign idx_nx = off_q + cnt_nx[OFF_W-1:0];
    assign len_m1 = (mode_q ? CW'(BEATS) - {1'b0, off_q} : CW'(BEATS)) - CW'(1);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        mode_d  = mode_q;
        off_d   = off_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rlast_d = rlast_q;
        if (pop) begin
            state_d = SEND;
            id_d    = in_id;
            mode_d  = in_mode;
            off_d   = in_off;
            line_d  = in_line;
            cnt_d   = '0;
            rdata_d = beat_of(in_line, in_off);
            rlast_d = in_mode & (in_off == OFF_W'(BEATS - 1));
        end else if (lacc) begin
            state_d = IDLE;
            rlast_d = 1'b0;
        end else if (acc) begin
            cnt_d   = cnt_nx;
            rdata_d = beat_of(line_q, idx_nx);
            rlast_d = cnt_nx == len_m1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            id_q    <= '0;
            mode_q  <= 1'b0;
            off_q   <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= 1'b1;
            id_q    <= id_d;
            mode_q  <= mode_d;
            off_q   <= off_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rlast_q <= rlast_d;
        end
    end

    assign fifo_rden_o = pop;
    assign rid_o       = id_q;
    assign rdata_o     = rdata_q;
    assign rlast_o     = rlast_q;
    assign rvalid_o    = state_q == SEND;
    assign busy_o      = state_q == SEND;
endmodule

// File: tb/tb_cc_line_serializer.sv
// tb_cc_line_serializer: directed bench for cc_line_serializer with a FIFO model
// and an expected-beat list checked on every accepted beat.
module tb_cc_line_serializer;
    localparam int DATA_W  = 64;
    localparam int BEATS   = 8;
    localparam int ID_W    = 4;
    localparam int ENTRY_W = ID_W + 1 + 3 + BEATS * DATA_W;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  id;
        logic        last;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               fifo_empty_i = 1'b1;
    logic [ENTRY_W-1:0] fifo_rdata_i = '0;
    logic               fifo_rden_o;
    logic [ID_W-1:0]    rid_o;
    logic [DATA_W-1:0]  rdata_o;
    logic               rlast_o;
    logic               rvalid_o;
    logic               rready_i = 1'b0;
    logic               busy_o;

    logic [ENTRY_W-1:0] fq[$];
    beat_t              eq[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 pops = 0;
    int                 accs = 0;
    logic               hold_v = 1'b0;
    logic [63:0]        hold_d;
    logic [3:0]         hold_id;
    logic               hold_l;

    cc_line_serializer dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i),
        .fifo_rden_o(fifo_rden_o), .rid_o(rid_o), .rdata_o(rdata_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] mk(input logic [3:0] id, input logic m, input logic [2:0] off);
        logic [BEATS*DATA_W-1:0] l;
        for (int k = 0; k < BEATS; k++) l[(BEATS-1-k)*DATA_W +: DATA_W] = {28'h0, id, 32'(k)};
        return {id, m, off, l};
    endfunction

    task automatic refresh();
        fifo_empty_i = fq.size() == 0;
        fifo_rdata_i = fq.size() != 0 ? fq[0] : '0;
    endtask

    // Queue an entry in the FIFO and list the beats it must produce.
    task automatic push(input logic [3:0] id, input logic m, input int off);
        int len;
        beat_t b;
        len = m ? BEATS - off : BEATS;
        for (int i = 0; i < len; i++) begin
            b.data = {28'h0, id, 32'((off + i) % BEATS)};
            b.id   = id;
            b.last = i == len - 1;
            eq.push_back(b);
        end
        fq.push_back(mk(id, m, 3'(off)));
        refresh();
    endtask

    // One clock: called at a negedge with inputs already driven.
    task automatic cyc();
        logic do_pop;
        beat_t e;
        #1;
        if (hold_v) begin
            chk("hold_valid", 64'(rvalid_o), 64'd1);
            chk("hold_data", rdata_o, hold_d);
            chk("hold_id", 64'(rid_o), 64'(hold_id));
            chk("hold_last", 64'(rlast_o), 64'(hold_l));
        end
        if (fifo_rden_o) chk("rden_empty", 64'(fifo_empty_i), 64'd0);
        chk("busy", 64'(busy_o), 64'(rvalid_o));
        do_pop = fifo_rden_o;
        hold_v = rvalid_o & !rready_i;
        hold_d = rdata_o;
        hold_id = rid_o;
        hold_l = rlast_o;
        if (rvalid_o && rready_i) begin
            accs++;
            if (eq.size() == 0) chk("extra_beat", 64'(rvalid_o), 64'd0);
            else begin
                e = eq.pop_front();
                chk("rdata", rdata_o, e.data);
                chk("rid", 64'(rid_o), 64'(e.id));
                chk("rlast", 64'(rlast_o), 64'(e.last));
            end
        end
        @(posedge clk);
        #1;
        if (do_pop) begin
            pops++;
            if (fq.size() != 0) void'(fq.pop_front());
            refresh();
        end
        @(negedge clk);
    endtask

    task automatic run(input int bound, input bit bp, output int n);
        n = 0;
        while (eq.size() != 0 && n < bound) begin
            if (bp) rready_i = (n % 3) == 0;
            cyc();
            n++;
        end
        chk("burst_timeout", 64'(eq.size()), 64'd0);
        rready_i = 1'b1;
    endtask

    initial begin
        int n, p0, a0;
        // Reset and idle
        #2;
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_rden", 64'(fifo_rden_o), 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_rvalid", 64'(rvalid_o), 64'd0);
            chk("idle_rden", 64'(fifo_rden_o), 64'd0);
            chk("idle_out", {rdata_o[59:0], rid_o}, 64'd0);
            chk("idle_last", 64'(rlast_o), 64'd0);
        end
        // Wrap, critical word first
        rready_i = 1'b1;
        p0 = pops;
        push(4'd3, 1'b0, 5);
        #1;
        chk("pop_now", 64'(fifo_rden_o), 64'd1);
        cyc();
        chk("latency_rvalid", 64'(rvalid_o), 64'd1);
        chk("first_data", rdata_o, {28'h0, 4'd3, 32'd5});
        run(40, 1'b0, n);
        chk("wrap_cycles", 64'(n), 64'd8);
        chk("wrap_pops", 64'(pops - p0), 64'd1);
        cyc();
        chk("wrap_idle", 64'(rvalid_o), 64'd0);
        // Incrementing modes
        push(4'd5, 1'b1, 6);
        run(40, 1'b0, n);
        chk("incr6_cycles", 64'(n), 64'd3);
        push(4'd6, 1'b1, 7);
        run(40, 1'b0, n);
        chk("incr7_cycles", 64'(n), 64'd2);
        push(4'd7, 1'b0, 0);
        run(40, 1'b0, n);
        chk("wrap0_cycles", 64'(n), 64'd9);
        cyc();
        // Backpressure
        p0 = pops;
        a0 = accs;
        push(4'd9, 1'b0, 2);
        run(80, 1'b1, n);
        chk("bp_accepts", 64'(accs - a0), 64'd8);
        chk("bp_pops", 64'(pops - p0), 64'd1);
        cyc();
        // Back-to-back lines
        p0 = pops;
        push(4'd1, 1'b0, 0);
        push(4'd2, 1'b0, 4);
        run(60, 1'b0, n);
        chk("b2b_cycles", 64'(n), 64'd17);
        chk("b2b_pops", 64'(pops - p0), 64'd2);
        cyc();
        // Mid-burst asynchronous reset
        push(4'd4, 1'b0, 0);
        a0 = accs;
        n = 0;
        while (accs - a0 < 3 && n < 20) begin
            cyc();
            n++;
        end
        chk("mid_accepts", 64'(accs - a0), 64'd3);
        chk("mid_valid_before", 64'(rvalid_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rvalid_async", 64'(rvalid_o), 64'd0);
        chk("mid_busy_async", 64'(busy_o), 64'd0);
        chk("mid_rden", 64'(fifo_rden_o), 64'd0);
        eq.delete();
        hold_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_idle", 64'(rvalid_o), 64'd0);
        push(4'd11, 1'b1, 4);
        run(40, 1'b0, n);
        chk("post_rst_cycles", 64'(n), 64'd5);
        cyc();
        chk("post_rst_end", 64'(rvalid_o), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
